addsub_nibble_sequencer: RTL and testbench
==========================================

Name: addsub_nibble_sequencer

Overview:
Multi-cycle WIDTH-bit adder/subtractor built on one 4-bit ripple-carry slice.
- Processes one nibble per clock, LSB first, holding the inter-nibble carry in a register.
- Uses valid/ready handshakes on both sides.
- Sits between an operand producer (e.g. ALU issue logic) and a result consumer, trading latency for area.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4, otherwise elaboration error.
- NIBBLES, WIDTH/4, derived number of slice passes; localparam, not overridable.

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand request valid.
- out_ready  output  1  sequencer can accept operands.
- in_x  input  WIDTH  operand X.
- in_y  input  WIDTH  operand Y.
- in_add_n  input  1  0 = X+Y, 1 = X-Y.
- out_valid  output  1  result valid.
- in_ready  input  1  consumer accepts result.
- out_s  output  WIDTH  sum/difference.
- out_c  output  1  final carry; for subtract, 1 = no borrow (X >= Y unsigned).
- out_busy  output  1  high in RUN or DONE.
- out_v  output  1  signed overflow; present only with the optional feature.

Behaviour:
- Clock and reset: one clock (in_clk). Reset in_rst_n is asynchronous, active-low.
- Reset values: state=IDLE, out_ready=1, out_valid=0, out_busy=0, out_s=0, out_c=0, out_v=0. Nibble counter, carry register and operand registers are 0.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - out_ready=1.
  - On in_valid & out_ready at edge E0: latch in_x, in_y and in_add_n; load carry register with in_add_n; clear counter and out_s; go to RUN.
- RUN:
  - out_ready=0.
  - At edge Ek (k=1..NIBBLES), compute nibble n=k-1: slice inputs are x[4n+3:4n], (y[4n+3:4n] XOR {4{add_n}}) and the carry register.
  - Write the 4-bit sum into out_s[4n+3:4n] and the slice carry into the carry register.
  - At edge E_NIBBLES, go to DONE and drive out_c from the slice carry.
  - in_valid is ignored throughout RUN.
- DONE:
  - out_valid=1; out_s, out_c and out_v are stable.
  - Hold indefinitely while in_ready=0.
  - On in_valid... no: on in_ready=1 at an edge, go to IDLE with out_valid=0. out_s and out_c keep their values until the next acceptance clears them.
- Latency: out_valid asserts exactly NIBBLES cycles after the acceptance edge. Throughput is one op per NIBBLES+2 cycles at best (ready only in IDLE; no back-to-back acceptance from DONE).
- Arithmetic: modulo 2^WIDTH. The result equals a single-cycle WIDTH-bit two's-complement add/sub with carry-in = add_n.
- Counter: width max(1, clog2(NIBBLES)). Counter wrap is not observable because the state leaves RUN at its last value.
- Reset mid-operation (RUN or DONE): immediate return to reset values; the partial result is discarded.
- NIBBLES=1: RUN lasts one edge.

Optional Feature:
- Macro ADDSUB_SEQ_OVERFLOW_EN.
- Defined: port out_v exists. At the final nibble, out_v = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, which needs a per-bit carry-3 tap from the slice (or recompute from bit 3 operands and sum). out_v is registered with out_c, 0 on reset, valid only while out_valid.
- Undefined: no out_v port and no overflow logic.

Decomposition:
- Package addsub_seq_pkg:
  - state enum (IDLE, RUN, DONE) typedef.
  - NIBBLE_W=4.
  - function computing the counter width.
- Sub-module: the existing Ripple_Carry_Adder_4bit slice, instanced once with explicit carry-in from the carry register. Operand inversion is done in the sequencer.

Test Plan (WIDTH=16):
- Add: X=0x1234, Y=0x0FFF, add_n=0 -> after 4 cycles out_valid=1, out_s=0x2233, out_c=0.
- Subtract with borrow: X=0x0005, Y=0x0007, add_n=1 -> out_s=0xFFFE, out_c=0. Then X=0x0007, Y=0x0005 -> out_s=0x0002, out_c=1.
- Wrap: X=0xFFFF, Y=0x0001, add_n=0 -> out_s=0x0000, out_c=1; with feature, out_v=0. X=0x7FFF, Y=0x0001 -> out_s=0x8000, out_v=1.
- Backpressure: hold in_ready=0 for 10 cycles in DONE -> out_valid, out_s and out_c stable, out_ready=0, and an in_valid pulse is not accepted. Raise in_ready -> IDLE next cycle, out_ready=1.
- Reset mid-RUN: assert in_rst_n=0 asynchronously after nibble 2 -> all outputs at reset values immediately. A new op after reset release yields a correct result.
- Randomized: 1000 random X/Y/add_n triples against a reference model, checking out_s, out_c and out_v, plus exact NIBBLES-cycle latency.

Source files
------------

// File: rtl/addsub_seq_pkg.sv
// Shared types and helpers for the nibble-serial adder/subtractor.
package addsub_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic int unsigned cnt_width(input int unsigned nibbles);
    return (nibbles <= 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/Ripple_Carry_Adder_4bit.sv
// 4-bit ripple-carry adder slice with explicit carry-in.
module Ripple_Carry_Adder_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int i = 0; i < 4; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    c_o = c[4];
  end

endmodule

// File: rtl/addsub_nibble_sequencer.sv
// Multi-cycle WIDTH-bit add/sub, one nibble per clock through a single 4-bit slice.
// Define ADDSUB_SEQ_OVERFLOW_EN to add the signed-overflow output out_v.
module addsub_nibble_sequencer
  import addsub_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_add_n,
  output logic             out_valid,
  input  logic             in_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_busy,
  output logic             out_c
`ifdef ADDSUB_SEQ_OVERFLOW_EN
  ,
  output logic             out_v
`endif
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned CntW    = cnt_width(NIBBLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
    $error("addsub_nibble_sequencer: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  x_q, x_d, y_q, y_d, s_q, s_d;
  logic              add_n_q, add_n_d;
  logic              c_q, c_d;
`ifdef ADDSUB_SEQ_OVERFLOW_EN
  logic              v_q, v_d;
`endif

  logic [NIBBLE_W-1:0] slice_a, slice_b, slice_s;
  logic                slice_co;

  // Select the active nibble; subtract is X + ~Y + 1 with the +1 preloaded as carry.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (cnt_q == CntW'(i)) begin
        slice_a = x_q[i*NIBBLE_W +: NIBBLE_W];
        slice_b = y_q[i*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{add_n_q}};
      end
    end
  end

  Ripple_Carry_Adder_4bit u_slice (
    .a_i (slice_a),
    .b_i (slice_b),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    x_d     = x_q;
    y_d     = y_q;
    add_n_d = add_n_q;
    s_d     = s_q;
    c_d     = c_q;
`ifdef ADDSUB_SEQ_OVERFLOW_EN
    v_d     = v_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          add_n_d = in_add_n;
          carry_d = in_add_n;
          cnt_d   = '0;
          s_d     = '0;
          c_d     = 1'b0;
`ifdef ADDSUB_SEQ_OVERFLOW_EN
          v_d     = 1'b0;
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (cnt_q == CntW'(i)) s_d[i*NIBBLE_W +: NIBBLE_W] = slice_s;
        end
        carry_d = slice_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          c_d     = slice_co;
`ifdef ADDSUB_SEQ_OVERFLOW_EN
          // Carry into the MSB is recovered from the MSB's operands and sum bit.
          v_d     = slice_co ^ (slice_a[3] ^ slice_b[3] ^ slice_s[3]);
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        if (in_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      add_n_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
`ifdef ADDSUB_SEQ_OVERFLOW_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      x_q     <= x_d;
      y_q     <= y_d;
      add_n_q <= add_n_d;
      s_q     <= s_d;
      c_q     <= c_d;
`ifdef ADDSUB_SEQ_OVERFLOW_EN
      v_q     <= v_d;
`endif
    end
  end

  assign out_ready = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_busy  = (state_q != StIdle);
  assign out_s     = s_q;
  assign out_c     = c_q;
`ifdef ADDSUB_SEQ_OVERFLOW_EN
  assign out_v     = v_q;
`endif

endmodule

// File: tb/tb_addsub_nibble_sequencer.sv
// Bench for addsub_nibble_sequencer: word-level reference model, per-cycle compare,
// directed literal cases and randomized traffic. Honours ADDSUB_SEQ_OVERFLOW_EN.
module tb_addsub_nibble_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  logic             in_clk   = 1'b0;
  logic             in_rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready = 1'b0;
  logic             in_add_n = 1'b0;
  logic [WIDTH-1:0] in_x     = '0;
  logic [WIDTH-1:0] in_y     = '0;
  logic             out_ready, out_valid, out_busy, out_c;
  logic [WIDTH-1:0] out_s;
`ifdef ADDSUB_SEQ_OVERFLOW_EN
  logic             out_v;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 in_clk = ~in_clk;

  addsub_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .in_clk    (in_clk),
    .in_rst_n  (in_rst_n),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_add_n  (in_add_n),
    .out_valid (out_valid),
    .in_ready  (in_ready),
    .out_s     (out_s),
    .out_busy  (out_busy),
    .out_c     (out_c)
`ifdef ADDSUB_SEQ_OVERFLOW_EN
    ,
    .out_v     (out_v)
`endif
  );

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Whole-word reference: returns {v, c, s}.
  function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic sub);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] s;
    logic             v;
    sum = {1'b0, x} + {1'b0, (sub ? ~y : y)} + (WIDTH+1)'(sub);
    s   = sum[WIDTH-1:0];
    if (sub) v = (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    else     v = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    return {v, sum[WIDTH], s};
  endfunction

  function automatic logic [WIDTH-1:0] low_mask(input int nibs);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) if (i < nibs * 4) m[i] = 1'b1;
    return m;
  endfunction

  // Model: latency countdown plus count of nibbles already written.
  logic [WIDTH-1:0] m_res   = '0;
  logic             m_c     = 1'b0;
  logic             m_v     = 1'b0;
  logic             m_valid = 1'b0;
  int               m_left  = 0;
  int               m_done  = 0;
  int               m_ops   = 0;

  always @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      m_res <= '0; m_c <= 1'b0; m_v <= 1'b0; m_valid <= 1'b0; m_left <= 0; m_done <= 0;
    end else if (m_valid) begin
      if (in_ready) begin
        m_valid <= 1'b0;
        m_ops   <= m_ops + 1;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= m_done + 1;
      if (m_left == 1) m_valid <= 1'b1;
    end else if (in_valid) begin
      {m_v, m_c, m_res} <= ref_op(in_x, in_y, in_add_n);
      m_left <= NIB;
      m_done <= 0;
    end
  end

  function automatic logic m_idle();
    return !m_valid && (m_left == 0);
  endfunction

  always @(negedge in_clk) begin
    chk("ready", WIDTH'(out_ready), WIDTH'(m_idle()));
    chk("busy", WIDTH'(out_busy), WIDTH'(!m_idle()));
    chk("valid", WIDTH'(out_valid), WIDTH'(m_valid));
    chk("s", out_s, m_res & low_mask(m_done));
    chk("c", WIDTH'(out_c), WIDTH'((m_done == NIB) ? m_c : 1'b0));
`ifdef ADDSUB_SEQ_OVERFLOW_EN
    chk("v", WIDTH'(out_v), WIDTH'((m_done == NIB) ? m_v : 1'b0));
`endif
  end

  task automatic wait_idle();
    int t = 0;
    while (!m_idle() && t < 50) begin
      @(posedge in_clk); #1;
      t++;
    end
    if (!m_idle()) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle timeout at %0t: got busy expected idle", $time);
    end
  endtask

  task automatic accept(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic a);
    in_x = x; in_y = y; in_add_n = a; in_valid = 1'b1;
    @(posedge in_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic a,
                        input logic [WIDTH-1:0] es, input logic ec, input logic ev);
    wait_idle();
    in_ready = 1'b0;
    accept(x, y, a);
    repeat (NIB - 1) @(posedge in_clk);
    #1 chk("lat_early", WIDTH'(out_valid), WIDTH'(1'b0));
    @(posedge in_clk); #1;
    chk("lat_valid", WIDTH'(out_valid), WIDTH'(1'b1));
    chk("lit_s", out_s, es);
    chk("lit_c", WIDTH'(out_c), WIDTH'(ec));
`ifdef ADDSUB_SEQ_OVERFLOW_EN
    chk("lit_v", WIDTH'(out_v), WIDTH'(ev));
`else
    if (ev === 1'bx) $display("note: unexpected x");
`endif
  endtask

  task automatic release_done();
    in_ready = 1'b1;
    @(posedge in_clk); #1;
    in_ready = 1'b0;
  endtask

  initial begin
    int target;
    int cyc;
    repeat (2) @(posedge in_clk);
    #1;
    chk("rst_ready", WIDTH'(out_ready), WIDTH'(1'b1));
    chk("rst_valid", WIDTH'(out_valid), WIDTH'(1'b0));
    chk("rst_busy", WIDTH'(out_busy), WIDTH'(1'b0));
    chk("rst_s", out_s, '0);
    chk("rst_c", WIDTH'(out_c), WIDTH'(1'b0));
    in_rst_n = 1'b1;
    @(posedge in_clk); #1;

    run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0); release_done();
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0); release_done();
    run_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0); release_done();
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0); release_done();
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Backpressure: DONE holds and ignores a stray request.
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 4);
      in_x = 16'hAAAA; in_y = 16'h5555;
      @(posedge in_clk); #1;
      chk("bp_valid", WIDTH'(out_valid), WIDTH'(1'b1));
      chk("bp_ready", WIDTH'(out_ready), WIDTH'(1'b0));
      chk("bp_s", out_s, 16'h8000);
    end
    in_valid = 1'b0;
    release_done();
    chk("rel_ready", WIDTH'(out_ready), WIDTH'(1'b1));
    chk("rel_valid", WIDTH'(out_valid), WIDTH'(1'b0));
    chk("rel_s_held", out_s, 16'h8000);

    // Asynchronous reset after two nibbles have been written.
    wait_idle();
    accept(16'h1111, 16'h2222, 1'b0);
    @(posedge in_clk);
    @(posedge in_clk);
    #3 in_rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", WIDTH'(out_ready), WIDTH'(1'b1));
    chk("mid_rst_valid", WIDTH'(out_valid), WIDTH'(1'b0));
    chk("mid_rst_busy", WIDTH'(out_busy), WIDTH'(1'b0));
    chk("mid_rst_s", out_s, '0);
    @(posedge in_clk); #1;
    in_rst_n = 1'b1;
    run_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0); release_done();
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1); release_done();

    // Randomized traffic; the per-cycle compare checks results and latency.
    target = m_ops + 1000;
    cyc = 0;
    while (m_ops < target && cyc < 40000) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_add_n = ($urandom_range(0, 1) == 1);
      in_x     = WIDTH'($urandom);
      in_y     = WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) in_x = 16'h7FFF;
      if ($urandom_range(0, 7) == 0) in_y = 16'h8000;
      in_ready = ($urandom_range(0, 2) != 0);
      @(posedge in_clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    in_ready = 1'b0;
    n_tests++;
    if (m_ops < target) begin
      n_fail++;
      $display("FAIL random_ops: got %0d ops expected %0d", m_ops, target);
    end
    @(posedge in_clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
